// File: rtl/wb_arbiter_pkg.sv
// Shared definitions for the write-back port arbiter: widths, source indices and
// the conflict detector helper.
package wb_arbiter_pkg;

    localparam int unsigned RF_ADDR_W = 5;
    localparam int unsigned RF_DATA_W = 32;
    localparam int unsigned CNT_WIDTH = 16;
    localparam int unsigned MAX_SRC   = 8;

    typedef enum logic [1:0] {
        SrcAlu = 2'd0,
        SrcLsu = 2'd1,
        SrcMdu = 2'd2
    } src_e;

    localparam int unsigned NUM_SRC_DEFAULT = int'(SrcMdu) + 1;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    // True when two or more sources are requesting in the same cycle.
    function automatic logic multi_valid(input logic [MAX_SRC-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < int'(MAX_SRC); i++) begin
            if (v[i]) begin
                n = n + 1;
            end
        end
        return n >= 2;
    endfunction

endpackage

// File: rtl/wb_arbiter_rr_arbiter.sv
// Round-robin grant generator: combinational one-hot grant searched upward from
// the registered pointer, which moves past the winner on every transfer.
module rr_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int unsigned NUM_SRC = NUM_SRC_DEFAULT,
    localparam int unsigned PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] i_valid,
    output logic [NUM_SRC-1:0] o_grant,
    output logic               o_xfer
);

    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] w_ptr_next;
    logic [PTR_W-1:0] w_win;
    logic [PTR_W-1:0] w_hi;
    logic [PTR_W-1:0] w_lo;
    logic             w_hi_found;
    logic             w_lo_found;
    logic             w_any;

    // Descending scan leaves the lowest valid index at/above the pointer in w_hi and
    // the lowest below it in w_lo; the latter is the wrap-around candidate.
    always_comb begin
        w_hi       = '0;
        w_lo       = '0;
        w_hi_found = 1'b0;
        w_lo_found = 1'b0;
        for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
            if (i_valid[i]) begin
                if (i >= int'(r_ptr)) begin
                    w_hi_found = 1'b1;
                    w_hi       = PTR_W'(i);
                end else begin
                    w_lo_found = 1'b1;
                    w_lo       = PTR_W'(i);
                end
            end
        end
        w_win = w_hi_found ? w_hi : w_lo;
        w_any = (w_hi_found || w_lo_found) && !reset;
    end

    always_comb begin
        o_grant = '0;
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            o_grant[i] = w_any && (w_win == PTR_W'(i));
        end
    end

    assign o_xfer = w_any;

    always_comb begin
        w_ptr_next = r_ptr;
        if (w_any) begin
            w_ptr_next = (w_win == PTR_W'(NUM_SRC - 1)) ? '0 : w_win + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= '0;
        end else begin
            r_ptr <= w_ptr_next;
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: picks one execution-unit result per cycle,
// registers it onto the write port and drops writes aimed at x0.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int unsigned NUM_SRC        = NUM_SRC_DEFAULT,
    parameter int unsigned REG_ADDR_WIDTH = RF_ADDR_W,
    parameter int unsigned DATA_WIDTH     = RF_DATA_W
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_SRC-1:0]                req_valid,
    input  logic [NUM_SRC*REG_ADDR_WIDTH-1:0] req_rd,
    input  logic [NUM_SRC*DATA_WIDTH-1:0]     req_data,
    output logic [NUM_SRC-1:0]                req_ready,
    output logic [REG_ADDR_WIDTH-1:0]         WrtBck_Addr,
    output logic [DATA_WIDTH-1:0]             WrtBck_Data,
    output logic                              Wr_En,
    output logic [CNT_WIDTH-1:0]              conflict_cnt
);

    logic [NUM_SRC-1:0]        w_grant;
    logic                      w_xfer;
    logic [REG_ADDR_WIDTH-1:0] w_rd;
    logic [DATA_WIDTH-1:0]     w_data;
    logic                      w_wr;
    logic                      w_conflict;

    logic                      r_wr_en;
    logic [REG_ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0]     r_data;
    logic [CNT_WIDTH-1:0]      r_cnt;

    rr_arbiter #(
        .NUM_SRC (NUM_SRC)
    ) u_rr_arbiter (
        .clk     (clk),
        .reset   (reset),
        .i_valid (req_valid),
        .o_grant (w_grant),
        .o_xfer  (w_xfer)
    );

    assign req_ready = w_grant;

    // Grant is one-hot, so an OR of masked slices is the payload mux.
    always_comb begin
        w_rd   = '0;
        w_data = '0;
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            if (w_grant[i]) begin
                w_rd   = w_rd   | req_rd[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
                w_data = w_data | req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign w_wr       = w_xfer && (w_rd != '0);
    assign w_conflict = multi_valid(MAX_SRC'(req_valid));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_en <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
            r_cnt   <= '0;
        end else begin
            r_wr_en <= w_wr;
            if (w_wr) begin
                r_addr <= w_rd;
                r_data <= w_data;
            end
            if (w_conflict && (r_cnt != CNT_MAX)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign Wr_En        = r_wr_en;
    assign WrtBck_Addr  = r_addr;
    assign WrtBck_Data  = r_data;
    assign conflict_cnt = r_cnt;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: a vector table walks the grant/pointer sequence,
// hand-written sequences cover reset and counter saturation.
module tb_wb_arbiter;

    logic        clk;
    logic        reset;
    logic [2:0]  req_valid;
    logic [14:0] req_rd;
    logic [95:0] req_data;
    logic [2:0]  req_ready;
    logic [4:0]  WrtBck_Addr;
    logic [31:0] WrtBck_Data;
    logic        Wr_En;
    logic [15:0] conflict_cnt;

    int total;
    int bad;

    wb_arbiter #(
        .NUM_SRC        (3),
        .REG_ADDR_WIDTH (5),
        .DATA_WIDTH     (32)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_rd       (req_rd),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .WrtBck_Addr  (WrtBck_Addr),
        .WrtBck_Data  (WrtBck_Data),
        .Wr_En        (Wr_En),
        .conflict_cnt (conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  valid;
        logic [14:0] rd;
        logic [95:0] data;
        logic [2:0]  exp_ready;
        logic        exp_we;
        logic [4:0]  exp_addr;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[15];

    function automatic vec_t mk(input logic [2:0] v,
                                input logic [4:0] r0, input logic [4:0] r1,
                                input logic [4:0] r2,
                                input logic [31:0] d0, input logic [31:0] d1,
                                input logic [31:0] d2,
                                input logic [2:0] er, input logic ew,
                                input logic [4:0] ea, input logic [31:0] ed);
        vec_t t;
        t.valid     = v;
        t.rd        = {r2, r1, r0};
        t.data      = {d2, d1, d0};
        t.exp_ready = er;
        t.exp_we    = ew;
        t.exp_addr  = ea;
        t.exp_data  = ed;
        return t;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        reset     = 1'b1;
        req_valid = '0;
        req_rd    = '0;
        req_data  = '0;

        // Round-robin with all sources valid, then single/idle/x0/back-pressure/collision.
        vecs[0]  = mk(3'b111, 5'd1, 5'd2, 5'd3, 32'hA0, 32'hA1, 32'hA2, 3'b001, 1'b1, 5'd1, 32'hA0);
        vecs[1]  = mk(3'b111, 5'd1, 5'd2, 5'd3, 32'hA0, 32'hA1, 32'hA2, 3'b010, 1'b1, 5'd2, 32'hA1);
        vecs[2]  = mk(3'b111, 5'd1, 5'd2, 5'd3, 32'hA0, 32'hA1, 32'hA2, 3'b100, 1'b1, 5'd3, 32'hA2);
        vecs[3]  = mk(3'b111, 5'd1, 5'd2, 5'd3, 32'hA0, 32'hA1, 32'hA2, 3'b001, 1'b1, 5'd1, 32'hA0);
        vecs[4]  = mk(3'b111, 5'd1, 5'd2, 5'd3, 32'hA0, 32'hA1, 32'hA2, 3'b010, 1'b1, 5'd2, 32'hA1);
        vecs[5]  = mk(3'b111, 5'd1, 5'd2, 5'd3, 32'hA0, 32'hA1, 32'hA2, 3'b100, 1'b1, 5'd3, 32'hA2);
        vecs[6]  = mk(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 3'b000, 1'b0, 5'd3, 32'hA2);
        vecs[7]  = mk(3'b010, 5'd0, 5'd5, 5'd0, 32'h0, 32'hDEADBEEF, 32'h0,
                      3'b010, 1'b1, 5'd5, 32'hDEADBEEF);
        vecs[8]  = mk(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 3'b000, 1'b0, 5'd5, 32'hDEADBEEF);
        vecs[9]  = mk(3'b001, 5'd0, 5'd0, 5'd0, 32'h1234, 32'h0, 32'h0,
                      3'b001, 1'b0, 5'd5, 32'hDEADBEEF);
        vecs[10] = mk(3'b101, 5'd7, 5'd0, 5'd9, 32'h70, 32'h0, 32'h90, 3'b100, 1'b1, 5'd9, 32'h90);
        vecs[11] = mk(3'b001, 5'd7, 5'd0, 5'd9, 32'h70, 32'h0, 32'h90, 3'b001, 1'b1, 5'd7, 32'h70);
        vecs[12] = mk(3'b110, 5'd0, 5'd4, 5'd4, 32'h0, 32'h41, 32'h42, 3'b010, 1'b1, 5'd4, 32'h41);
        vecs[13] = mk(3'b100, 5'd0, 5'd4, 5'd4, 32'h0, 32'h41, 32'h42, 3'b100, 1'b1, 5'd4, 32'h42);
        vecs[14] = mk(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 3'b000, 1'b0, 5'd4, 32'h42);

        // Reset held three cycles with every source requesting.
        tick();
        req_valid = 3'b111;
        req_rd    = {5'd3, 5'd2, 5'd1};
        req_data  = {32'hA2, 32'hA1, 32'hA0};
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("reset_ready", 64'(req_ready), 64'h0);
            tick();
        end
        chk("reset_we", 64'(Wr_En), 64'h0);
        chk("reset_addr", 64'(WrtBck_Addr), 64'h0);
        chk("reset_data", 64'(WrtBck_Data), 64'h0);
        chk("reset_cnt", 64'(conflict_cnt), 64'h0);

        reset = 1'b0;
        for (int v = 0; v < 15; v++) begin
            req_valid = vecs[v].valid;
            req_rd    = vecs[v].rd;
            req_data  = vecs[v].data;
            #1;
            chk($sformatf("vec%0d_ready", v), 64'(req_ready), 64'(vecs[v].exp_ready));
            tick();
            chk($sformatf("vec%0d_we", v), 64'(Wr_En), 64'(vecs[v].exp_we));
            chk($sformatf("vec%0d_addr", v), 64'(WrtBck_Addr), 64'(vecs[v].exp_addr));
            chk($sformatf("vec%0d_data", v), 64'(WrtBck_Data), 64'(vecs[v].exp_data));
            if (v == 5) begin
                chk("rr_cnt", 64'(conflict_cnt), 64'd6);
            end
        end
        chk("table_cnt", 64'(conflict_cnt), 64'd8);

        // Move the pointer to 1, then let reset coincide with a src1 grant.
        req_valid = 3'b001;
        req_rd    = {5'd0, 5'd0, 5'd10};
        req_data  = {32'h0, 32'h0, 32'hB0};
        #1;
        chk("pre_rst_ready", 64'(req_ready), 64'b001);
        tick();
        chk("pre_rst_we", 64'(Wr_En), 64'h1);
        chk("pre_rst_addr", 64'(WrtBck_Addr), 64'd10);

        reset     = 1'b1;
        req_valid = 3'b010;
        req_rd    = {5'd0, 5'd6, 5'd0};
        req_data  = {32'h0, 32'h66, 32'h0};
        #1;
        chk("midrst_ready", 64'(req_ready), 64'h0);
        tick();
        chk("midrst_we", 64'(Wr_En), 64'h0);
        chk("midrst_addr", 64'(WrtBck_Addr), 64'h0);
        chk("midrst_data", 64'(WrtBck_Data), 64'h0);
        chk("midrst_cnt", 64'(conflict_cnt), 64'h0);

        // Pointer back at 0: src1 beats src2; a stale pointer of 2 would pick src2.
        reset     = 1'b0;
        req_valid = 3'b110;
        req_rd    = {5'd11, 5'd6, 5'd0};
        req_data  = {32'hBB, 32'h66, 32'h0};
        #1;
        chk("post_rst_ready", 64'(req_ready), 64'b010);
        tick();
        chk("post_rst_we", 64'(Wr_En), 64'h1);
        chk("post_rst_addr", 64'(WrtBck_Addr), 64'd6);
        chk("post_rst_data", 64'(WrtBck_Data), 64'h66);
        chk("post_rst_cnt", 64'(conflict_cnt), 64'd1);

        // Saturation: count is 1, so 65540 more conflict cycles must pin it at FFFF.
        req_valid = 3'b011;
        req_rd    = {5'd0, 5'd2, 5'd1};
        req_data  = {32'h0, 32'h21, 32'h11};
        for (int c = 0; c < 65540; c++) begin
            tick();
        end
        chk("sat_cnt", 64'(conflict_cnt), 64'hFFFF);
        req_valid = 3'b000;
        tick();
        chk("sat_hold", 64'(conflict_cnt), 64'hFFFF);
        chk("idle_we", 64'(Wr_En), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
